// File: rtl/psram_spi_responder_pkg.sv
// Command codes, responder states and the read-ID byte selector shared by the
// PSRAM SPI responder and the driver-side command definitions.
package psram_spi_responder_pkg;

   localparam logic [7:0] CMD_RESET_ENABLE = 8'h66;
   localparam logic [7:0] CMD_RESET        = 8'h99;
   localparam logic [7:0] CMD_READ_ID      = 8'h9F;
   localparam logic [7:0] CMD_READ         = 8'h03;
   localparam logic [7:0] CMD_WRITE        = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RDATA,
      ST_IDOUT,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   typedef enum logic [1:0] {
      MODE_READ,
      MODE_ID,
      MODE_WRITE
   } mode_t;

   // Byte idx of the read-ID stream: MFID, KGD, EID MSB first, then zeros.
   function automatic logic [7:0] id_byte(input logic [3:0] idx, input logic [7:0] mfid,
                                          input logic [7:0] kgd, input logic [47:0] eid);
      case (idx)
         4'd0:    id_byte = mfid;
         4'd1:    id_byte = kgd;
         4'd2:    id_byte = eid[47:40];
         4'd3:    id_byte = eid[39:32];
         4'd4:    id_byte = eid[31:24];
         4'd5:    id_byte = eid[23:16];
         4'd6:    id_byte = eid[15:8];
         4'd7:    id_byte = eid[7:0];
         default: id_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/psram_spi_responder_spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection on sclk and ce_n.
module spi_pin_sync (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic ce_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ce_rise,
   output logic ce_fall,
   output logic mosi_s
);

   logic [2:0] sclk_q;
   logic [2:0] ce_q;
   logic [1:0] mosi_q;

   // ce_n history clears low so a chip-enable already asserted at reset
   // release produces no falling edge and cannot start a transaction.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sclk_q <= '0;
         ce_q   <= '0;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         ce_q   <= {ce_q[1:0], ce_n};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ce_rise   = ce_q[1] & ~ce_q[2];
   assign ce_fall   = ~ce_q[1] & ce_q[2];
   assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/psram_spi_responder.sv
// IPS6404L-style serial PSRAM responder (reset, read-ID, linear read/write),
// oversampling the SPI pins in the sysclk domain with an internal byte store.
module psram_spi_responder
   import psram_spi_responder_pkg::*;
#(
   parameter int unsigned MEM_ADDR_BITS = 10,
   parameter logic [7:0]  MFID          = 8'h0D,
   parameter logic [7:0]  KGD           = 8'h5D,
   parameter logic [47:0] EID           = 48'h0
) (
   input  logic                     sysclk,
   input  logic                     reset,
   input  logic                     spi_sclk,
   input  logic                     spi_ce_n,
   input  logic                     spi_mosi,
   output logic                     spi_miso,
   output logic                     spi_miso_oe,
   output logic                     reset_done,
   output logic                     wr_strobe,
   output logic [MEM_ADDR_BITS-1:0] wr_addr,
   output logic [7:0]               wr_data,
   output logic [7:0]               last_cmd
);

   localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

   logic sclk_rise, sclk_fall, ce_rise, ce_fall, mosi_s;
   logic take, give, byte_in, addr_in, mem_we;
   state_t state, state_next;
   mode_t mode;
   logic [4:0]               bit_cnt;
   logic [23:0]              shreg;
   logic [23:0]              addr_full;
   logic [7:0]               rx_byte;
   logic [MEM_ADDR_BITS-1:0] ptr;
   logic [3:0]               id_idx;
   logic [7:0]               tx_sh;
   logic [7:0]               tx_src;
   logic [7:0]               mem_q;
   logic                     reset_armed;
   logic [7:0]               mem [DEPTH];

   spi_pin_sync u_sync (
      .clk       (sysclk),
      .reset     (reset),
      .sclk      (spi_sclk),
      .ce_n      (spi_ce_n),
      .mosi      (spi_mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ce_rise   (ce_rise),
      .ce_fall   (ce_fall),
      .mosi_s    (mosi_s)
   );

   // A chip-enable release outranks any sclk edge seen in the same cycle.
   assign take      = sclk_rise & ~ce_rise;
   assign give      = sclk_fall & ~ce_rise;
   assign rx_byte   = {shreg[6:0], mosi_s};
   assign addr_full = {shreg[22:0], mosi_s};
   assign byte_in   = take & (bit_cnt[2:0] == 3'd7);
   assign addr_in   = take & (bit_cnt == 5'd23);
   assign mem_we    = reset & (state == ST_WDATA) & byte_in;
   assign tx_src    = (state == ST_IDOUT) ? id_byte(id_idx, MFID, KGD, EID) : mem_q;

   always_ff @(posedge sysclk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (ce_fall) state_next = ST_CMD;
         ST_CMD: begin
            if (byte_in) begin
               if (rx_byte == CMD_READ_ID || rx_byte == CMD_READ || rx_byte == CMD_WRITE)
                  state_next = ST_ADDR;
               else
                  state_next = ST_IGNORE;
            end
         end
         ST_ADDR: begin
            if (addr_in) begin
               case (mode)
                  MODE_READ: state_next = ST_RDATA;
                  MODE_ID:   state_next = ST_IDOUT;
                  default:   state_next = ST_WDATA;
               endcase
            end
         end
         default: ;
      endcase
      if (ce_rise) state_next = ST_IDLE;
   end

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         reset_done  <= 1'b0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         last_cmd    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         ptr         <= '0;
         id_idx      <= '0;
         tx_sh       <= '0;
         reset_armed <= 1'b0;
         mode        <= MODE_READ;
      end else begin
         reset_done <= 1'b0;
         wr_strobe  <= 1'b0;
         if (ce_rise) begin
            bit_cnt     <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (ce_fall) bit_cnt <= '0;
               ST_CMD: begin
                  if (take) begin
                     shreg   <= {shreg[22:0], mosi_s};
                     bit_cnt <= byte_in ? 5'd0 : bit_cnt + 5'd1;
                  end
                  if (byte_in) begin
                     last_cmd    <= rx_byte;
                     reset_armed <= (rx_byte == CMD_RESET_ENABLE);
                     reset_done  <= (rx_byte == CMD_RESET) && reset_armed;
                     if (rx_byte == CMD_READ_ID)    mode <= MODE_ID;
                     else if (rx_byte == CMD_WRITE) mode <= MODE_WRITE;
                     else                           mode <= MODE_READ;
                  end
               end
               ST_ADDR: begin
                  if (take) begin
                     shreg   <= {shreg[22:0], mosi_s};
                     bit_cnt <= addr_in ? 5'd0 : bit_cnt + 5'd1;
                  end
                  if (addr_in) begin
                     ptr    <= addr_full[MEM_ADDR_BITS-1:0];
                     id_idx <= '0;
                  end
               end
               // Byte n+1 is prefetched into mem_q between the fall that
               // sends bit 0 of byte n and the next fall.
               ST_RDATA, ST_IDOUT: begin
                  if (give) begin
                     spi_miso_oe <= 1'b1;
                     if (bit_cnt[2:0] == 3'd0) begin
                        spi_miso <= tx_src[7];
                        tx_sh    <= {tx_src[6:0], 1'b0};
                     end else begin
                        spi_miso <= tx_sh[7];
                        tx_sh    <= {tx_sh[6:0], 1'b0};
                     end
                     bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                     if (bit_cnt[2:0] == 3'd7) begin
                        if (state == ST_RDATA)  ptr    <= ptr + MEM_ADDR_BITS'(1);
                        else if (id_idx != 4'd8) id_idx <= id_idx + 4'd1;
                     end
                  end
               end
               ST_WDATA: begin
                  if (take) begin
                     shreg   <= {shreg[22:0], mosi_s};
                     bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                  end
                  if (byte_in) begin
                     wr_strobe <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= rx_byte;
                     ptr       <= ptr + MEM_ADDR_BITS'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (mem_we) mem[ptr] <= rx_byte;
      mem_q <= mem[ptr];
   end

endmodule
